// File: rtl/dot_matrix_scanner.sv
// rtl/dot_matrix_scanner.sv - multiplexed row-scan driver for side-by-side LED dot-matrix panels
//
// Double-buffered frame store, loaded row by row; buffers swap only at a frame
// boundary so a displayed frame is never torn. Selected panels blink from an
// internal divider of the scan clock.
//
// Ports:
//   clk_10000Hz    in   scan clock, one row per cycle
//   reset          in   synchronous, active-high
//   wr_valid       in   write request for the back buffer
//   wr_ready       out  back buffer accepts writes (~reset & ~commit_pending)
//   wr_row         in   row index to write
//   wr_data        in   row pixels, panel 0 in MSBs, MSB = leftmost
//   commit         in   pulse: request swap at next frame end
//   commit_pending out  swap requested, not yet done
//   blink_en       in   enable blinking
//   blink_mask     in   bit p=1: panel p blinks
//   dot_row        out  row select, row 0 = MSB
//   dot_col        out  column data, 1 = LED on
//   frame_start    out  high while row 0 is displayed
module dot_matrix_scanner #(
  parameter int PANELS         = 2,
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int BLINK_HALF     = 2500
) (
  input  logic                      clk_10000Hz,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [PANELS*COLS-1:0]    wr_data,
  input  logic                      commit,
  output logic                      commit_pending,
  input  logic                      blink_en,
  input  logic [PANELS-1:0]         blink_mask,
  output logic [ROWS-1:0]           dot_row,
  output logic [PANELS*COLS-1:0]    dot_col,
  output logic                      frame_start
);

  localparam int W  = PANELS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [RW-1:0]   LAST_ROW   = RW'(ROWS - 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_HALF - 1);
  // Idle level of every row line; XOR with a one-hot select gives the driven pattern.
  localparam logic [ROWS-1:0] ROW_IDLE   = {ROWS{ROW_ACTIVE_LOW != 0}};

  logic [W-1:0]    buf0 [ROWS];
  logic [W-1:0]    buf1 [ROWS];
  logic            front_sel;   // 0: buf0 is displayed, 1: buf1 is displayed
  logic [RW-1:0]   scan_row;
  logic [BW-1:0]   blink_cnt;
  logic            phase;       // free-running blink phase, 1 = on
  logic            phase_f;     // phase frozen for the whole displayed frame

  logic [ROWS-1:0] row_sel;
  logic [W-1:0]    front_row;
  logic [W-1:0]    col_mask;
  logic            wr_fire;
  logic            at_end;

  assign wr_ready = ~reset & ~commit_pending;
  assign wr_fire  = wr_valid & wr_ready;
  assign at_end   = (scan_row == LAST_ROW);

  always_comb begin
    row_sel = '0;
    // Row 0 sits in the MSB of dot_row.
    row_sel[LAST_ROW - scan_row] = 1'b1;

    front_row = front_sel ? buf1[scan_row] : buf0[scan_row];

    col_mask = '1;
    for (int p = 0; p < PANELS; p++) begin
      if (blink_mask[p] && !phase_f) begin
        col_mask[(PANELS-1-p)*COLS +: COLS] = '0;
      end
    end
  end

  always_ff @(posedge clk_10000Hz) begin
    if (reset) begin
      scan_row       <= '0;
      dot_row        <= ROW_IDLE;
      dot_col        <= '0;
      frame_start    <= 1'b0;
      commit_pending <= 1'b0;
      front_sel      <= 1'b0;
      blink_cnt      <= '0;
      phase          <= 1'b1;
      phase_f        <= 1'b1;
      for (int r = 0; r < ROWS; r++) begin
        buf0[r] <= '0;
        buf1[r] <= '0;
      end
    end else begin
      // ROWS is a power of two, so the natural wrap of scan_row is the row wrap.
      scan_row    <= scan_row + 1'b1;
      dot_row     <= ROW_IDLE ^ row_sel;
      dot_col     <= front_row & col_mask;
      frame_start <= (scan_row == '0);

      // Writes always target the buffer that is not displayed.
      if (wr_fire) begin
        if (front_sel) buf0[wr_row] <= wr_data;
        else           buf1[wr_row] <= wr_data;
      end

      // A commit seen during the swap cycle is only ignored if already pending,
      // so a fresh commit there is deferred to the following frame end.
      if (at_end && commit_pending) begin
        front_sel      <= ~front_sel;
        commit_pending <= 1'b0;
      end else if (commit && !commit_pending) begin
        commit_pending <= 1'b1;
      end

      if (!blink_en) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (at_end) begin
        phase_f <= phase;
      end
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb/tb_dot_matrix_scanner.sv - self-checking bench for dot_matrix_scanner
`timescale 1ns/1ps
module tb_dot_matrix_scanner;

  localparam int BH = 2500;

  logic        clk_10000Hz = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_row = '0;
  logic [15:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        commit_pending;
  logic        blink_en = 1'b0;
  logic [1:0]  blink_mask = '0;
  logic [7:0]  dot_row;
  logic [15:0] dot_col;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: whole frames as arrays, blink phase from a count of enabled cycles.
  int          m_row = 0;
  logic [15:0] m_front [8];
  logic [15:0] m_back  [8];
  bit          m_pending = 1'b0;
  int          m_en = 0;
  bit          m_pf = 1'b1;
  logic [7:0]  e_row = 8'hFF;
  logic [15:0] e_col = '0;
  logic        e_fs = 1'b0;

  dot_matrix_scanner #(
    .PANELS(2), .ROWS(8), .COLS(8), .ROW_ACTIVE_LOW(1), .BLINK_HALF(BH)
  ) dut (
    .clk_10000Hz    (clk_10000Hz),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_row         (wr_row),
    .wr_data        (wr_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .blink_en       (blink_en),
    .blink_mask     (blink_mask),
    .dot_row        (dot_row),
    .dot_col        (dot_col),
    .frame_start    (frame_start)
  );

  always #50 clk_10000Hz = ~clk_10000Hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] cmask(input bit pf, input logic [1:0] bm);
    logic [15:0] m;
    m = 16'hFFFF;
    if (!pf && bm[0]) m[15:8] = 8'h00;
    if (!pf && bm[1]) m[7:0]  = 8'h00;
    return m;
  endfunction

  // Advance the model across one clock edge, then compare every output.
  task automatic tick();
    logic [15:0] t;
    if (reset) begin
      m_row = 0;
      for (int r = 0; r < 8; r++) begin
        m_front[r] = '0;
        m_back[r]  = '0;
      end
      m_pending = 1'b0;
      m_en = 0;
      m_pf = 1'b1;
      e_row = 8'hFF;
      e_col = '0;
      e_fs = 1'b0;
    end else begin
      e_row = ~(8'h80 >> m_row);
      e_fs  = (m_row == 0);
      e_col = m_front[m_row] & cmask(m_pf, blink_mask);
      if (wr_valid && !m_pending) m_back[wr_row] = wr_data;
      if (m_row == 7 && m_pending) begin
        for (int r = 0; r < 8; r++) begin
          t = m_front[r];
          m_front[r] = m_back[r];
          m_back[r] = t;
        end
        m_pending = 1'b0;
      end else if (commit && !m_pending) begin
        m_pending = 1'b1;
      end
      if (m_row == 7) m_pf = ((m_en / BH) % 2) == 0;
      m_en  = blink_en ? m_en + 1 : 0;
      m_row = (m_row + 1) % 8;
    end
    @(posedge clk_10000Hz);
    #1;
    chk("dot_row", dot_row, e_row);
    chk("dot_col", dot_col, e_col);
    chk("frame_start", frame_start, e_fs);
    chk("commit_pending", commit_pending, m_pending);
    chk("wr_ready", wr_ready, !reset && !m_pending);
  endtask

  task automatic wait_row(input int r);
    for (int n = 0; n < 16 && m_row != r; n++) tick();
  endtask

  task automatic wait_swap();
    for (int n = 0; n < 40 && m_pending; n++) tick();
  endtask

  task automatic load_all(input logic [15:0] base, input logic [15:0] step);
    wr_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      wr_row  = 3'(r);
      wr_data = base + 16'(r) * step;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int run;
    int longest_off;
    int seen_on;
    int seen_off;

    // 1: reset then idle scan
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_dot_row", dot_row, 8'hFF);
    chk("rst_dot_col", dot_col, 16'h0000);
    chk("rst_wr_ready", wr_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk("idle_first_row", dot_row, 8'h7F);
    chk("idle_first_fs", frame_start, 1'b1);
    repeat (8) tick();

    // 2: load 3C81, commit mid-frame
    wr_valid = 1'b1;
    wr_data  = 16'h3C81;
    for (int r = 0; r < 8; r++) begin
      wr_row = 3'(r);
      tick();
    end
    wr_valid = 1'b0;
    wait_row(3);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("t2_pending", commit_pending, 1'b1);
    chk("t2_wr_ready", wr_ready, 1'b0);
    wait_swap();
    tick();
    chk("t2_new_frame_row", dot_row, 8'h7F);
    chk("t2_new_frame_col", dot_col, 16'h3C81);

    // 3: commit in the scan_row=7 cycle defers the swap by one frame
    load_all(16'h1000, 16'h0101);
    wait_row(7);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (7) tick();
    chk("t3_still_pending", commit_pending, 1'b1);
    chk("t3_old_front", dot_col, 16'h3C81);
    tick();
    chk("t3_swapped", commit_pending, 1'b0);
    tick();
    chk("t3_new_row0", dot_col, 16'h1000);

    // 4: blink panel 1 over an all-on frame
    load_all(16'hFFFF, 16'h0000);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_swap();
    blink_en   = 1'b1;
    blink_mask = 2'b10;
    run = 0;
    longest_off = 0;
    seen_on = 0;
    seen_off = 0;
    for (int i = 0; i < 6200; i++) begin
      tick();
      if (dot_col == 16'hFF00) begin
        seen_off++;
        run++;
      end else begin
        if (dot_col == 16'hFFFF) seen_on++;
        if (run > longest_off) longest_off = run;
        run = 0;
      end
    end
    chk("t4_seen_on", seen_on != 0, 1'b1);
    chk("t4_seen_off", seen_off != 0, 1'b1);
    chk("t4_off_len_frames", longest_off % 8, 0);
    chk("t4_off_len_range", (longest_off >= 2496) && (longest_off <= 2504), 1'b1);
    blink_en = 1'b0;
    blink_mask = 2'b00;
    repeat (16) tick();

    // 5: reset mid-frame with a pending swap
    wait_row(0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_row(5);
    chk("t5_pending_before", commit_pending, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_pending", commit_pending, 1'b0);
    chk("t5_dot_col", dot_col, 16'h0000);
    chk("t5_dot_row", dot_row, 8'hFF);
    chk("t5_fs", frame_start, 1'b0);
    repeat (9) tick();

    // 6: wr_valid held while pending; accepted the cycle after the swap
    load_all(16'h0200, 16'h0011);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wr_valid = 1'b1;
    wr_row   = 3'd2;
    wr_data  = 16'hBEEF;
    wait_swap();
    chk("t6_ready_after_swap", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    wait_row(3);
    chk("t6_front_row2_old", dot_col, 16'h0222);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_swap();
    wait_row(3);
    chk("t6_front_row2_new", dot_col, 16'hBEEF);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      wr_valid   = $urandom_range(0, 1) == 1;
      wr_row     = 3'($urandom_range(0, 7));
      wr_data    = 16'($urandom);
      commit     = $urandom_range(0, 7) == 0;
      blink_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) blink_en = ~blink_en;
      reset      = $urandom_range(0, 149) == 0;
      tick();
    end
    reset = 1'b0;
    wr_valid = 1'b0;
    commit = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
